inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/rv_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/inst_fetch.sv | 70 +++++++
 tb/tb_inst_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-unit constants and fetch FSM state encoding
package rv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int QDEPTH = 2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular queue of {pc, instruction} entries with clear
module fetch_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  // storage write; a write during clear is harmless since pointers reset
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers and occupancy; clear wins over any same-edge pop
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(do_pop);
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch FSM feeding a small queue
module inst_fetch #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int ILEN = rv_pkg::ILEN,
  parameter int QDEPTH = rv_pkg::QDEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  input  logic            flush,
  output logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  import rv_pkg::*;
  localparam int CW = $clog2(QDEPTH + 1);
  fetch_state_e state;
  logic [XLEN-1:0] addr;
  logic drop, accept, push;
  logic [CW-1:0] count;
  logic [XLEN+ILEN-1:0] dout;
  assign accept = pc_valid && state == IDLE && count < CW'(QDEPTH) && !flush;
  assign stall = pc_valid && !accept && !flush;
  assign imem_req = state == REQ;
  assign imem_addr = addr;
  assign push = state == WAIT && imem_rvalid && !drop && !flush;
  assign inst_valid = count != '0;
  assign inst = dout[ILEN-1:0];
  assign inst_pc = dout[ILEN+:XLEN];
  // fetch sequencing; drop marks an in-flight response killed by a redirect
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      drop <= 1'b0;
    end else
      case (state)
        IDLE: if (accept) begin
          addr <= pc;
          state <= REQ;
        end
        REQ: begin
          if (imem_gnt) state <= WAIT;
          if (flush) drop <= 1'b1;
        end
        WAIT: if (imem_rvalid) begin
          state <= IDLE;
          drop <= 1'b0;
        end else if (flush) drop <= 1'b1;
        default: state <= IDLE;
      endcase
  fetch_fifo #(.W(XLEN + ILEN), .DEPTH(QDEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(inst_valid && inst_ready),
    .clear(flush),
    .din({addr, imem_rdata}),
    .dout(dout),
    .count(count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed table plus hand sequences for inst_fetch
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst_n, pc_valid, flush, imem_gnt, imem_rvalid, inst_ready;
  logic [63:0] pc;
  logic [31:0] imem_rdata;
  logic stall, imem_req, inst_valid;
  logic [63:0] imem_addr, inst_pc;
  logic [31:0] inst;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic pv;
    logic [63:0] pc;
    logic gnt, rv;
    logic [31:0] rd;
    logic rdy;
    logic es, er;
    logic [63:0] ea;
    logic ev;
    logic [31:0] ei;
    logic [63:0] ep;
  } vec_t;
  vec_t q[$];
  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fetch(input logic [63:0] a, input logic [31:0] d);
    pc = a;
    pc_valid = 1'b1;
    #1 chk("fetch_accept_stall", stall, 0);
    step;
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, a);
    step;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = d;
    step;
    imem_rvalid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; inst_ready = 1'b0; pc = '0; imem_rdata = '0;
    q.push_back('{1, 64'h0,  0, 0, 32'h0,        1, 0, 0, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  1, 0, 32'h0,        1, 0, 1, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  0, 1, 32'h00500093, 1, 0, 0, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  0, 0, 32'h0,        1, 0, 0, 64'h0,  1, 32'h00500093, 64'h0});
    q.push_back('{0, 64'h0,  0, 0, 32'h0,        1, 0, 0, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{1, 64'h0,  0, 0, 32'h0,        0, 0, 0, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  1, 0, 32'h0,        0, 0, 1, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  0, 1, 32'h11111111, 0, 0, 0, 64'h0,  0, 32'h0,        64'h0});
    q.push_back('{1, 64'h40, 0, 0, 32'h0,        0, 0, 0, 64'h0,  1, 32'h11111111, 64'h0});
    q.push_back('{0, 64'h0,  1, 0, 32'h0,        0, 0, 1, 64'h40, 1, 32'h11111111, 64'h0});
    q.push_back('{0, 64'h0,  0, 1, 32'h22222222, 1, 0, 0, 64'h40, 1, 32'h11111111, 64'h0});
    q.push_back('{0, 64'h0,  0, 0, 32'h0,        0, 0, 0, 64'h40, 1, 32'h22222222, 64'h40});
    q.push_back('{0, 64'h0,  0, 0, 32'h0,        1, 0, 0, 64'h40, 1, 32'h22222222, 64'h40});
    q.push_back('{0, 64'h0,  0, 1, 32'hdeadbeef, 0, 0, 0, 64'h40, 0, 32'h0,        64'h0});
    q.push_back('{0, 64'h0,  0, 0, 32'h0,        0, 0, 0, 64'h40, 0, 32'h0,        64'h0});
    @(negedge clk);
    step;
    #1 chk("rst_stall", stall, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (q[i]) begin
      pc_valid = q[i].pv; pc = q[i].pc; imem_gnt = q[i].gnt;
      imem_rvalid = q[i].rv; imem_rdata = q[i].rd; inst_ready = q[i].rdy;
      #1 chk($sformatf("v%0d_stall", i), stall, q[i].es);
      chk($sformatf("v%0d_req", i), imem_req, q[i].er);
      chk($sformatf("v%0d_addr", i), imem_addr, q[i].ea);
      chk($sformatf("v%0d_valid", i), inst_valid, q[i].ev);
      if (q[i].ev) begin
        chk($sformatf("v%0d_inst", i), inst, q[i].ei);
        chk($sformatf("v%0d_pc", i), inst_pc, q[i].ep);
      end
      step;
    end
    pc_valid = 0; imem_gnt = 0; imem_rvalid = 0; inst_ready = 0;
    fetch(64'h0, 32'h00000013);
    fetch(64'h40, 32'h00000113);
    pc = 64'h80;
    pc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_stall", stall, 1);
      chk("full_noreq", imem_req, 0);
      chk("full_head", inst, 32'h00000013);
      step;
    end
    inst_ready = 1'b1;
    #1 chk("full_pop_stall", stall, 1);
    step;
    inst_ready = 1'b0;
    #1 chk("after_pop_stall", stall, 0);
    chk("after_pop_head", inst, 32'h00000113);
    chk("after_pop_pc", inst_pc, 64'h40);
    step;
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("f80_req", imem_req, 1);
    chk("f80_addr", imem_addr, 64'h80);
    step;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00000213;
    step;
    imem_rvalid = 1'b0;
    inst_ready = 1'b1;
    #1 chk("drain0", inst, 32'h00000113);
    step;
    #1 chk("drain1", inst, 32'h00000213);
    chk("drain1_pc", inst_pc, 64'h80);
    step;
    inst_ready = 1'b0;
    #1 chk("drain_empty", inst_valid, 0);
    pc = 64'h40;
    pc_valid = 1'b1;
    #1 chk("hold_accept", stall, 0);
    step;
    for (int k = 0; k < 5; k++) begin
      imem_rvalid = k == 2;
      imem_rdata = 32'hbad0bad0;
      #1 chk("hold_req", imem_req, 1);
      chk("hold_addr", imem_addr, 64'h40);
      chk("hold_stall", stall, 1);
      step;
    end
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("hold_req_gnt", imem_req, 1);
    step;
    imem_gnt = 1'b0;
    pc_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00a00113;
    #1 chk("hold_wait_noreq", imem_req, 0);
    chk("hold_no_early", inst_valid, 0);
    step;
    imem_rvalid = 1'b0;
    #1 chk("hold_inst", inst, 32'h00a00113);
    chk("hold_pc", inst_pc, 64'h40);
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    fetch(64'h100, 32'haaaa0001);
    pc = 64'h140;
    pc_valid = 1'b1;
    step;
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step;
    imem_gnt = 1'b0;
    flush = 1'b1;
    pc_valid = 1'b1;
    #1 chk("flush_valid_before", inst_valid, 1);
    chk("flush_stall", stall, 0);
    step;
    flush = 1'b0;
    pc_valid = 1'b0;
    #1 chk("flush_cleared", inst_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hbbbb0002;
    step;
    imem_rvalid = 1'b0;
    #1 chk("flush_dropped", inst_valid, 0);
    pc = 64'h200;
    pc_valid = 1'b1;
    #1 chk("flush_next_accept", stall, 0);
    step;
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("flush_next_req", imem_req, 1);
    chk("flush_next_addr", imem_addr, 64'h200);
    step;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hcccc0003;
    step;
    imem_rvalid = 1'b0;
    #1 chk("flush_next_inst", inst, 32'hcccc0003);
    chk("flush_next_pc", inst_pc, 64'h200);
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
    pc = 64'h300;
    pc_valid = 1'b1;
    step;
    pc_valid = 1'b0;
    imem_gnt = 1'b1;
    step;
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hdddd0004;
    #1 chk("rstmid_req", imem_req, 0);
    step;
    imem_rvalid = 1'b0;
    #1 chk("rstmid_valid", inst_valid, 0);
    chk("rstmid_req2", imem_req, 0);
    chk("rstmid_addr", imem_addr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
